cmd_dispatch: RTL and testbench

CMD_DISPATCH -- requirements
Module: cmd_dispatch

---
 rtl/cmd_dispatch.sv | 134 +++++++++++++
 tb/tb_cmd_dispatch.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_dispatch.sv
// cmd_dispatch: pops commands from a first-word-fall-through FIFO, holds reads
// until the target bank has a free read credit, then presents the command to
// that bank until the bank accepts it. One command in flight at a time.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | nothing held; pop the FIFO head as soon as it is present
// HOLD  | command captured; writes move on, reads wait for a bank credit
// ISSUE | command presented one-hot to its bank until that bank is ready
module cmd_dispatch #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANK   = 4,
  parameter int MAX_CREDIT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  output logic [DATA_WIDTH-1:0] o_cmd,
  output logic [NUM_BANK-1:0]   o_cmd_valid,
  input  logic [NUM_BANK-1:0]   i_bank_ready,
  input  logic [NUM_BANK-1:0]   i_rd_done,
  output logic                  o_busy,
  output logic                  o_credit_err,
  output logic [15:0]           o_issue_cnt
);

  localparam int BANK_BITS = $clog2(NUM_BANK);
  localparam int CW        = $clog2(MAX_CREDIT) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] cmd_reg_q, cmd_reg_d;
  logic [CW-1:0]         credit_q [NUM_BANK];
  logic [CW-1:0]         credit_d [NUM_BANK];
  logic                  credit_err_q, credit_err_d;
  logic [15:0]           issue_cnt_q, issue_cnt_d;

  logic                  cmd_is_wr;
  logic [BANK_BITS-1:0]  cmd_bank;
  logic                  bank_has_credit;
  logic                  consume;

  assign cmd_is_wr       = cmd_reg_q[DATA_WIDTH-1];
  assign cmd_bank        = cmd_reg_q[DATA_WIDTH-2 -: BANK_BITS];
  // Registered credit only: a return this cycle unblocks HOLD on the next edge.
  assign bank_has_credit = (credit_q[cmd_bank] != '0);

  assign o_cmd        = cmd_reg_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_credit_err = credit_err_q;
  assign o_issue_cnt  = issue_cnt_q;

  // Next-state, command capture, pop/valid strobes and issue counting.
  always_comb begin
    state_d      = state_q;
    cmd_reg_d    = cmd_reg_q;
    issue_cnt_d  = issue_cnt_q;
    o_fifo_rd_en = 1'b0;
    o_cmd_valid  = '0;
    consume      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Reset gates the pop so nothing is taken while the block is held.
        if (!i_fifo_empty && i_rst_n) begin
          o_fifo_rd_en = 1'b1;
          cmd_reg_d    = i_fifo_data;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cmd_is_wr) begin
          state_d = S_ISSUE;
        end else if (bank_has_credit) begin
          consume = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_cmd_valid[cmd_bank] = 1'b1;
        if (i_bank_ready[cmd_bank]) begin
          state_d     = S_IDLE;
          issue_cnt_d = issue_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-bank credit bookkeeping; a simultaneous return and consume cancel out.
  always_comb begin
    credit_err_d = credit_err_q;
    for (int b = 0; b < NUM_BANK; b++) begin
      credit_d[b] = credit_q[b];
      if (i_rd_done[b] && !(consume && (cmd_bank == BANK_BITS'(b)))) begin
        if (credit_q[b] == CW'(MAX_CREDIT)) begin
          credit_err_d = 1'b1;
        end else begin
          credit_d[b] = credit_q[b] + CW'(1);
        end
      end else if (!i_rd_done[b] && consume && (cmd_bank == BANK_BITS'(b))) begin
        credit_d[b] = credit_q[b] - CW'(1);
      end
    end
  end

  // State, held command, credits, error flag and issue counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      cmd_reg_q    <= '0;
      credit_err_q <= 1'b0;
      issue_cnt_q  <= '0;
      for (int b = 0; b < NUM_BANK; b++) begin
        credit_q[b] <= CW'(MAX_CREDIT);
      end
    end else begin
      state_q      <= state_d;
      cmd_reg_q    <= cmd_reg_d;
      credit_err_q <= credit_err_d;
      issue_cnt_q  <= issue_cnt_d;
      for (int b = 0; b < NUM_BANK; b++) begin
        credit_q[b] <= credit_d[b];
      end
    end
  end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Testbench for cmd_dispatch: the bench plays the FIFO and the bank
// controllers, and predicts behaviour from a transaction-level model.
`timescale 1ns/1ps
module tb_cmd_dispatch;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int MC = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [DW-1:0] i_fifo_data;
  logic          i_fifo_empty;
  logic          o_fifo_rd_en;
  logic [DW-1:0] o_cmd;
  logic [NB-1:0] o_cmd_valid;
  logic [NB-1:0] i_bank_ready;
  logic [NB-1:0] i_rd_done;
  logic          o_busy;
  logic          o_credit_err;
  logic [15:0]   o_issue_cnt;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] fq[$];
  int            exp_cnt = 0;
  int            mcred[NB];
  logic          exp_err = 1'b0;

  cmd_dispatch #(.DATA_WIDTH(DW), .NUM_BANK(NB), .MAX_CREDIT(MC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_fifo_data(i_fifo_data),
    .i_fifo_empty(i_fifo_empty), .o_fifo_rd_en(o_fifo_rd_en), .o_cmd(o_cmd),
    .o_cmd_valid(o_cmd_valid), .i_bank_ready(i_bank_ready), .i_rd_done(i_rd_done),
    .o_busy(o_busy), .o_credit_err(o_credit_err), .o_issue_cnt(o_issue_cnt)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mk_cmd(input logic wr, input logic [1:0] bank,
                                           input logic [28:0] pl);
    return {wr, bank, pl};
  endfunction

  task automatic set_fifo();
    i_fifo_empty = (fq.size() == 0);
    i_fifo_data  = (fq.size() == 0) ? '0 : fq[0];
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  // Called right after sample(): commits the pop the DUT requested this cycle.
  task automatic advance();
    logic pop;
    pop = o_fifo_rd_en;
    @(posedge i_clk);
    #1;
    if (pop && fq.size() > 0) fq.delete(0);
    i_rd_done = '0;
    set_fifo();
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic give_done(input int b, input int n);
    for (int k = 0; k < n; k++) begin
      i_rd_done[b] = 1'b1;
      if (mcred[b] == MC) exp_err = 1'b1;
      else mcred[b]++;
      sample();
      advance();
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_bank_ready = '0; i_rd_done = '0;
    for (int b = 0; b < NB; b++) mcred[b] = MC;
    fq.push_back(mk_cmd(1'b1, 2'd0, 29'h0123456));
    set_fifo();
    repeat (3) @(posedge i_clk);
    #1;
    sample();
    checks++; if (o_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b exp 0", o_fifo_rd_en); end
    checks++; if (o_cmd_valid !== 4'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0000", o_cmd_valid); end
    checks++; if (o_cmd !== 32'h0) begin errors++; $display("FAIL reset_cmd: got %h exp 0", o_cmd); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", o_busy); end
    checks++; if (o_credit_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", o_credit_err); end
    checks++; if (o_issue_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h exp 0", o_issue_cnt); end
    for (int b = 0; b < NB; b++) begin
      checks++; if (dut.credit_q[b] !== 4'(mcred[b])) begin errors++; $display("FAIL reset_credit[%0d]: got %0d exp %0d", b, dut.credit_q[b], mcred[b]); end
    end
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_bank_ready = '1;
    sample();
    checks++; if (o_fifo_rd_en !== 1'b1) begin errors++; $display("FAIL release_first_pop: got %b exp 1", o_fifo_rd_en); end
    advance();
    repeat (3) cycle();
    exp_cnt = 1;
    sample();
    checks++; if (o_issue_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL release_cnt: got %0d exp %0d", o_issue_cnt, exp_cnt); end
    advance();
  endtask

  task automatic test_write_bank2();
    logic [DW-1:0] w;
    w = 32'hC0DE_1234;
    i_bank_ready = '1;
    fq.push_back(w);
    set_fifo();
    sample();
    checks++; if (o_fifo_rd_en !== 1'b1) begin errors++; $display("FAIL wr_pop_T: got %b exp 1", o_fifo_rd_en); end
    advance(); sample();
    checks++; if (o_cmd_valid !== 4'b0 || o_busy !== 1'b1 || o_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL wr_T1: valid %b busy %b rd_en %b exp 0000 1 0", o_cmd_valid, o_busy, o_fifo_rd_en); end
    advance(); sample();
    checks++; if (o_cmd_valid !== 4'b0100) begin errors++; $display("FAIL wr_valid_T2: got %b exp 0100", o_cmd_valid); end
    checks++; if (o_cmd !== w) begin errors++; $display("FAIL wr_cmd_T2: got %h exp %h", o_cmd, w); end
    advance(); sample();
    exp_cnt++;
    checks++; if (o_issue_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL wr_cnt: got %0d exp %0d", o_issue_cnt, exp_cnt); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL wr_idle: busy %b exp 0", o_busy); end
    for (int b = 0; b < NB; b++) begin
      checks++; if (dut.credit_q[b] !== 4'(mcred[b])) begin errors++; $display("FAIL wr_credit[%0d]: got %0d exp %0d", b, dut.credit_q[b], mcred[b]); end
    end
    advance();
  endtask

  task automatic test_credit_exhaust();
    int issued;
    issued = 0;
    i_bank_ready = '1;
    for (int i = 0; i < 9; i++) fq.push_back(mk_cmd(1'b0, 2'd0, 29'(i + 16)));
    set_fifo();
    for (int c = 0; c < 40; c++) begin
      sample();
      if (o_cmd_valid[0] && i_bank_ready[0]) issued++;
      advance();
    end
    mcred[0] -= 8; exp_cnt += 8;
    sample();
    checks++; if (issued !== 8) begin errors++; $display("FAIL exhaust_issued: got %0d exp 8", issued); end
    checks++; if (o_cmd_valid !== 4'b0 || o_busy !== 1'b1 || o_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL exhaust_hold: valid %b busy %b rd_en %b exp 0000 1 0", o_cmd_valid, o_busy, o_fifo_rd_en); end
    checks++; if (dut.credit_q[0] !== 4'(mcred[0])) begin errors++; $display("FAIL exhaust_credit: got %0d exp %0d", dut.credit_q[0], mcred[0]); end
    advance();
    i_rd_done = 4'b0001; mcred[0]++;
    sample();
    checks++; if (o_cmd_valid !== 4'b0) begin errors++; $display("FAIL return_t0: valid %b exp 0000", o_cmd_valid); end
    advance(); sample();
    checks++; if (o_cmd_valid !== 4'b0) begin errors++; $display("FAIL return_t1: valid %b exp 0000", o_cmd_valid); end
    advance(); sample();
    checks++; if (o_cmd_valid !== 4'b0001) begin errors++; $display("FAIL return_t2: valid %b exp 0001", o_cmd_valid); end
    mcred[0]--; exp_cnt++;
    advance();
    repeat (2) cycle();
    sample();
    checks++; if (o_issue_cnt !== 16'(exp_cnt) || dut.credit_q[0] !== 4'(mcred[0])) begin errors++; $display("FAIL exhaust_end: cnt %0d credit %0d exp %0d %0d", o_issue_cnt, dut.credit_q[0], exp_cnt, mcred[0]); end
    advance();
    give_done(0, 8);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w, w2;
    w  = mk_cmd(1'b0, 2'd3, 29'h1ABCDEF);
    w2 = mk_cmd(1'b1, 2'd1, 29'h0555AAA);
    i_bank_ready = 4'b0111;
    fq.push_back(w); fq.push_back(w2);
    set_fifo();
    cycle(); cycle();
    mcred[3]--;
    for (int k = 0; k < 5; k++) begin
      sample();
      checks++; if (o_cmd_valid !== 4'b1000 || o_cmd !== w) begin errors++; $display("FAIL bp_stable[%0d]: valid %b cmd %h exp 1000 %h", k, o_cmd_valid, o_cmd, w); end
      checks++; if (o_fifo_rd_en !== 1'b0 || o_issue_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL bp_hold[%0d]: rd_en %b cnt %0d exp 0 %0d", k, o_fifo_rd_en, o_issue_cnt, exp_cnt); end
      advance();
    end
    i_bank_ready = 4'b1000;
    sample();
    checks++; if (o_cmd_valid !== 4'b1000) begin errors++; $display("FAIL bp_ready_cycle: valid %b exp 1000", o_cmd_valid); end
    advance();
    exp_cnt++;
    sample();
    checks++; if (o_issue_cnt !== 16'(exp_cnt) || o_fifo_rd_en !== 1'b1) begin errors++; $display("FAIL bp_after: cnt %0d rd_en %b exp %0d 1", o_issue_cnt, o_fifo_rd_en, exp_cnt); end
    advance();
    i_bank_ready = '1;
    repeat (3) cycle();
    exp_cnt++;
    sample();
    checks++; if (dut.credit_q[3] !== 4'(mcred[3]) || dut.credit_q[1] !== 4'(mcred[1])) begin errors++; $display("FAIL bp_credit: b3 %0d b1 %0d exp %0d %0d", dut.credit_q[3], dut.credit_q[1], mcred[3], mcred[1]); end
    advance();
  endtask

  task automatic test_simul_credit();
    i_bank_ready = '1;
    for (int i = 0; i < 5; i++) fq.push_back(mk_cmd(1'b0, 2'd1, 29'(i + 100)));
    set_fifo();
    repeat (20) cycle();
    mcred[1] -= 5; exp_cnt += 5;
    fq.push_back(mk_cmd(1'b0, 2'd1, 29'h0777));
    set_fifo();
    sample();
    checks++; if (dut.credit_q[1] !== 4'(mcred[1]) || o_fifo_rd_en !== 1'b1) begin errors++; $display("FAIL simul_pre: credit %0d rd_en %b exp %0d 1", dut.credit_q[1], o_fifo_rd_en, mcred[1]); end
    advance();
    i_rd_done = 4'b0010;
    sample();
    advance();
    sample();
    checks++; if (o_cmd_valid !== 4'b0010) begin errors++; $display("FAIL simul_valid: got %b exp 0010", o_cmd_valid); end
    checks++; if (dut.credit_q[1] !== 4'(mcred[1])) begin errors++; $display("FAIL simul_credit: got %0d exp %0d", dut.credit_q[1], mcred[1]); end
    advance();
    exp_cnt++;
    repeat (2) cycle();
    give_done(1, 5);
  endtask

  task automatic test_overflow();
    give_done(3, 1);
    sample();
    checks++; if (dut.credit_q[3] !== 4'(mcred[3]) || o_credit_err !== exp_err) begin errors++; $display("FAIL ovf_pre: credit %0d err %b exp %0d %b", dut.credit_q[3], o_credit_err, mcred[3], exp_err); end
    advance();
    give_done(3, 1);
    sample();
    checks++; if (dut.credit_q[3] !== 4'(mcred[3]) || o_credit_err !== exp_err || exp_err !== 1'b1) begin errors++; $display("FAIL ovf_set: credit %0d err %b exp %0d 1", dut.credit_q[3], o_credit_err, mcred[3]); end
    advance();
    repeat (5) cycle();
    sample();
    checks++; if (o_credit_err !== exp_err) begin errors++; $display("FAIL ovf_sticky: err %b exp %b", o_credit_err, exp_err); end
    advance();
  endtask

  task automatic test_reset_mid_issue();
    logic [DW-1:0] w, w2;
    int issued;
    w  = mk_cmd(1'b0, 2'd2, 29'($urandom));
    w2 = mk_cmd(1'b1, 2'd0, 29'($urandom));
    issued = 0;
    i_bank_ready = '0;
    fq.push_back(w);
    set_fifo();
    cycle(); cycle();
    sample();
    checks++; if (o_cmd_valid !== 4'b0100) begin errors++; $display("FAIL mid_pre_valid: got %b exp 0100", o_cmd_valid); end
    advance();
    fq.push_back(w2);
    set_fifo();
    #1; i_rst_n = 1'b0; #1;
    exp_cnt = 0; exp_err = 1'b0;
    for (int b = 0; b < NB; b++) mcred[b] = MC;
    checks++; if (o_cmd_valid !== 4'b0 || o_cmd !== 32'h0 || o_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL mid_async: valid %b cmd %h rd_en %b exp 0000 0 0", o_cmd_valid, o_cmd, o_fifo_rd_en); end
    checks++; if (o_busy !== 1'b0 || o_credit_err !== exp_err || o_issue_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL mid_status: busy %b err %b cnt %0d exp 0 0 0", o_busy, o_credit_err, o_issue_cnt); end
    for (int b = 0; b < NB; b++) begin
      checks++; if (dut.credit_q[b] !== 4'(mcred[b])) begin errors++; $display("FAIL mid_credit[%0d]: got %0d exp %0d", b, dut.credit_q[b], mcred[b]); end
    end
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_bank_ready = '1;
    for (int c = 0; c < 12; c++) begin
      sample();
      if (o_cmd_valid != 4'b0) begin
        issued++;
        checks++; if (o_cmd !== w2) begin errors++; $display("FAIL mid_reissue: cmd %h exp %h", o_cmd, w2); end
      end
      advance();
    end
    exp_cnt = 1;
    sample();
    checks++; if (issued !== 1 || o_issue_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL mid_after: issued %0d cnt %0d exp 1 %0d", issued, o_issue_cnt, exp_cnt); end
    advance();
  endtask

  task automatic test_random();
    logic [DW-1:0] expq[$];
    logic [DW-1:0] c, hd;
    logic [1:0]    bk;
    int            outst[NB];
    int            cyc;
    for (int b = 0; b < NB; b++) outst[b] = 0;
    for (int i = 0; i < 150; i++) begin
      c = $urandom;
      c[31] = ($urandom_range(0, 3) == 0);
      expq.push_back(c);
      fq.push_back(c);
    end
    set_fifo();
    cyc = 0;
    while (expq.size() > 0 && cyc < 6000) begin
      i_bank_ready = 4'($urandom);
      for (int b = 0; b < NB; b++) begin
        if (outst[b] > 0 && $urandom_range(0, 19) == 0) begin
          i_rd_done[b] = 1'b1;
          outst[b]--;
        end
      end
      sample();
      if (o_cmd_valid != 4'b0) begin
        hd = expq[0];
        bk = hd[30:29];
        checks++; if (o_cmd_valid !== (4'b0001 << bk) || o_cmd !== hd) begin errors++; $display("FAIL rnd_cmd: valid %b cmd %h exp %b %h", o_cmd_valid, o_cmd, 4'b0001 << bk, hd); end
        if (i_bank_ready[bk]) begin
          if (!hd[31]) begin
            outst[bk]++;
            checks++; if (outst[bk] > MC) begin errors++; $display("FAIL rnd_outstanding: bank %0d has %0d exp <= %0d", bk, outst[bk], MC); end
          end
          exp_cnt++;
          expq.delete(0);
        end
      end
      advance();
      cyc++;
    end
    checks++; if (expq.size() != 0) begin errors++; $display("FAIL rnd_timeout: %0d left exp 0", expq.size()); end
    for (int b = 0; b < NB; b++) begin
      mcred[b] = MC - outst[b];
      give_done(b, outst[b]);
    end
    sample();
    for (int b = 0; b < NB; b++) begin
      checks++; if (dut.credit_q[b] !== 4'(mcred[b])) begin errors++; $display("FAIL rnd_credit[%0d]: got %0d exp %0d", b, dut.credit_q[b], mcred[b]); end
    end
    checks++; if (o_issue_cnt !== 16'(exp_cnt) || o_credit_err !== exp_err) begin errors++; $display("FAIL rnd_end: cnt %0d err %b exp %0d %b", o_issue_cnt, o_credit_err, exp_cnt, exp_err); end
    advance();
  endtask

  task automatic test_counter_wrap();
    force dut.issue_cnt_q = 16'hFFFE;
    #1;
    release dut.issue_cnt_q;
    exp_cnt = 16'hFFFE;
    i_bank_ready = '1;
    sample();
    checks++; if (o_issue_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL wrap_preset: got %h exp %h", o_issue_cnt, exp_cnt); end
    advance();
    for (int k = 0; k < 2; k++) begin
      fq.push_back(mk_cmd(1'b1, 2'(k), 29'(k)));
      set_fifo();
      repeat (4) cycle();
      exp_cnt = (exp_cnt + 1) % 65536;
      sample();
      checks++; if (o_issue_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL wrap_step[%0d]: got %h exp %h", k, o_issue_cnt, exp_cnt); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_write_bank2();
    test_credit_exhaust();
    test_backpressure();
    test_simul_credit();
    test_overflow();
    test_reset_mid_issue();
    test_random();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
